// File: rtl/ps2_command_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ps2_command_scheduler
// Description : PS/2 set-2 scan-code parser driving game commands
//               (move left/right, rate-limited fire, pause toggle).
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_command_scheduler #(
    parameter int COOLDOWN_CYCLES = 2500000,
    parameter int PREFIX_TIMEOUT  = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_key_pressed,
    input  logic [7:0] ps2_key_data,
    input  logic       game_active,
    output logic       move_left,
    output logic       move_right,
    output logic       fire,
    output logic       pause,
    output logic [1:0] parse_state
);

    localparam int CD_W = $clog2(COOLDOWN_CYCLES + 1);
    localparam int TO_W = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(PREFIX_TIMEOUT - 1);
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [CD_W-1:0] cd_q, cd_d;
    logic            left_held_q, left_held_d;
    logic            right_held_q, right_held_d;
    logic            last_dir_q, last_dir_d;
    logic            p_held_q, p_held_d;
    logic            pause_q, pause_d;
    logic            fire_q, fire_d;
    logic            move_left_q, move_left_d;
    logic            move_right_q, move_right_d;

    logic key_valid, key_ext, key_break;
    logic is_left, is_right, is_fire, is_pause;

    // Parser: a strobe always takes priority over the prefix timeout.
    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        key_valid = 1'b0;
        key_ext   = 1'b0;
        key_break = 1'b0;
        if (ps2_key_pressed) begin
            to_cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (ps2_key_data == 8'hE0)      state_d = EXT;
                    else if (ps2_key_data == 8'hF0) state_d = BRK;
                    else                            key_valid = 1'b1;
                end
                EXT: begin
                    if (ps2_key_data == 8'hF0)      state_d = EXT_BRK;
                    else if (ps2_key_data == 8'hE0) state_d = EXT;
                    else begin
                        key_valid = 1'b1;
                        key_ext   = 1'b1;
                        state_d   = IDLE;
                    end
                end
                BRK: begin
                    key_valid = 1'b1;
                    key_break = 1'b1;
                    state_d   = IDLE;
                end
                EXT_BRK: begin
                    key_valid = 1'b1;
                    key_ext   = 1'b1;
                    key_break = 1'b1;
                    state_d   = IDLE;
                end
            endcase
        end else if (state_q != IDLE) begin
            if (to_cnt_q == TO_LAST) begin
                state_d  = IDLE;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    // Key actions; outputs are computed from next-state values so they
    // appear exactly one clock after the strobe.
    always_comb begin
        is_left  = key_valid & (key_ext ? (ps2_key_data == 8'h6B) : (ps2_key_data == 8'h1C));
        is_right = key_valid & (key_ext ? (ps2_key_data == 8'h74) : (ps2_key_data == 8'h23));
        is_fire  = key_valid & ~key_ext & (ps2_key_data == 8'h29);
        is_pause = key_valid & ~key_ext & (ps2_key_data == 8'h4D);

        left_held_d  = is_left  ? ~key_break : left_held_q;
        right_held_d = is_right ? ~key_break : right_held_q;
        p_held_d     = is_pause ? ~key_break : p_held_q;

        last_dir_d = last_dir_q;
        if (is_left & ~key_break)       last_dir_d = DIR_LEFT;
        else if (is_right & ~key_break) last_dir_d = DIR_RIGHT;

        pause_d = pause_q;
        if (!game_active)                             pause_d = 1'b0;
        else if (is_pause & ~key_break & ~p_held_q)   pause_d = ~pause_q;

        fire_d = is_fire & ~key_break & (cd_q == '0) & game_active & ~pause_q;

        cd_d = cd_q;
        if (fire_d)          cd_d = CD_LOAD;
        else if (cd_q != '0) cd_d = cd_q - CD_W'(1);

        move_left_d  = game_active & ~pause_d & left_held_d &
                       (~right_held_d | (last_dir_d == DIR_LEFT));
        move_right_d = game_active & ~pause_d & right_held_d &
                       (~left_held_d | (last_dir_d == DIR_RIGHT));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            to_cnt_q     <= '0;
            cd_q         <= '0;
            left_held_q  <= 1'b0;
            right_held_q <= 1'b0;
            last_dir_q   <= DIR_LEFT;
            p_held_q     <= 1'b0;
            pause_q      <= 1'b0;
            fire_q       <= 1'b0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            to_cnt_q     <= to_cnt_d;
            cd_q         <= cd_d;
            left_held_q  <= left_held_d;
            right_held_q <= right_held_d;
            last_dir_q   <= last_dir_d;
            p_held_q     <= p_held_d;
            pause_q      <= pause_d;
            fire_q       <= fire_d;
            move_left_q  <= move_left_d;
            move_right_q <= move_right_d;
        end
    end

    assign move_left   = move_left_q;
    assign move_right  = move_right_q;
    assign fire        = fire_q;
    assign pause       = pause_q;
    assign parse_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_command_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_command_scheduler
// Description : Scoreboard bench for ps2_command_scheduler (directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_command_scheduler;

    logic       clk;
    logic       rst;
    logic       ps2_key_pressed;
    logic [7:0] ps2_key_data;
    logic       game_active;
    logic       move_left, move_right, fire, pause;
    logic [1:0] parse_state;

    ps2_command_scheduler #(
        .COOLDOWN_CYCLES(8),
        .PREFIX_TIMEOUT (16)
    ) dut (
        .clock          (clk),
        .reset          (rst),
        .ps2_key_pressed(ps2_key_pressed),
        .ps2_key_data   (ps2_key_data),
        .game_active    (game_active),
        .move_left      (move_left),
        .move_right     (move_right),
        .fire           (fire),
        .pause          (pause),
        .parse_state    (parse_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Expected output vector {move_left, move_right, fire, pause, parse_state}
    int         q_cyc[$];
    logic [5:0] q_val[$];
    string      q_nm[$];
    int         n_pass  = 0;
    int         n_total = 0;
    logic [5:0] mon_act;

    function automatic logic [5:0] o(input logic ml, input logic mr, input logic f,
                                     input logic p, input logic [1:0] ps);
        return {ml, mr, f, p, ps};
    endfunction

    always @(negedge clk) begin
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            mon_act = {move_left, move_right, fire, pause, parse_state};
            n_total++;
            if (q_cyc[0] == cyc && mon_act == q_val[0]) n_pass++;
            else $display("FAIL %s: got ml,mr,f,p,ps=%b expected %b (cycle %0d, due %0d)",
                          q_nm[0], mon_act, q_val[0], cyc, q_cyc[0]);
            void'(q_cyc.pop_front());
            void'(q_val.pop_front());
            void'(q_nm.pop_front());
        end
    end

    task automatic expect_at(input int when, input string nm, input logic [5:0] v);
        q_cyc.push_back(when);
        q_val.push_back(v);
        q_nm.push_back(nm);
    endtask

    task automatic drive(input logic [7:0] code);
        ps2_key_pressed = 1'b1;
        ps2_key_data    = code;
        @(negedge clk);
        ps2_key_pressed = 1'b0;
        ps2_key_data    = 8'h00;
    endtask

    task automatic send(input logic [7:0] code, input string nm, input logic [5:0] v);
        expect_at(cyc + 1, nm, v);
        drive(code);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int c0;
        rst             = 1'b1;
        ps2_key_pressed = 1'b0;
        ps2_key_data    = 8'h00;
        game_active     = 1'b0;
        @(negedge clk);
        expect_at(cyc + 1, "reset_state", o(0, 0, 0, 0, 2'd0));
        @(negedge clk);
        rst         = 1'b0;
        game_active = 1'b1;
        idle(2);

        // Extended left make / break
        send(8'hE0, "e0_to_ext",      o(0, 0, 0, 0, 2'd1));
        send(8'h6B, "ext_left_make",  o(1, 0, 0, 0, 2'd0));
        send(8'hE0, "e0_left_held",   o(1, 0, 0, 0, 2'd1));
        send(8'hF0, "f0_to_ext_brk",  o(1, 0, 0, 0, 2'd3));
        send(8'h6B, "ext_left_break", o(0, 0, 0, 0, 2'd0));

        // Last direction wins while both are held
        send(8'hE0, "e0_a",           o(0, 0, 0, 0, 2'd1));
        send(8'h6B, "hold_left",      o(1, 0, 0, 0, 2'd0));
        send(8'hE0, "e0_b",           o(1, 0, 0, 0, 2'd1));
        send(8'h74, "press_right",    o(0, 1, 0, 0, 2'd0));
        send(8'hE0, "e0_c",           o(0, 1, 0, 0, 2'd1));
        send(8'hF0, "f0_c",           o(0, 1, 0, 0, 2'd3));
        send(8'h74, "release_right",  o(1, 0, 0, 0, 2'd0));
        send(8'hE0, "e0_d",           o(1, 0, 0, 0, 2'd1));
        send(8'hF0, "f0_d",           o(1, 0, 0, 0, 2'd3));
        send(8'h6B, "release_left",   o(0, 0, 0, 0, 2'd0));
        idle(2);

        // Fire cooldown: makes at t=0,3,9 fire at t+1 for t=0 and 9 only
        c0 = cyc;
        for (int k = 1; k <= 10; k++)
            expect_at(c0 + k, $sformatf("fire_cd_t%0d", k),
                      o(0, 0, (k == 1 || k == 10), 0, 2'd0));
        drive(8'h29);
        idle(2);
        drive(8'h29);
        idle(5);
        drive(8'h29);
        idle(10);

        // Pause toggle with typematic repeat, fire blocked while paused
        send(8'h4D, "pause_make",      o(0, 0, 0, 1, 2'd0));
        send(8'h29, "no_fire_paused",  o(0, 0, 0, 1, 2'd0));
        send(8'h4D, "pause_repeat",    o(0, 0, 0, 1, 2'd0));
        send(8'hF0, "pause_f0",        o(0, 0, 0, 1, 2'd2));
        send(8'h4D, "pause_break",     o(0, 0, 0, 1, 2'd0));
        send(8'h4D, "pause_off",       o(0, 0, 0, 0, 2'd0));
        send(8'h29, "fire_unpaused",   o(0, 0, 1, 0, 2'd0));
        idle(10);

        // Extended 29 must not fire
        send(8'hE0, "e0_ext29",        o(0, 0, 0, 0, 2'd1));
        send(8'h29, "ext29_no_fire",   o(0, 0, 0, 0, 2'd0));

        // Prefix timeout abandons E0; following 6B is a normal (unmapped) code
        send(8'hE0, "e0_timeout",      o(0, 0, 0, 0, 2'd1));
        expect_at(cyc + 15, "ext_before_to", o(0, 0, 0, 0, 2'd1));
        expect_at(cyc + 16, "idle_after_to", o(0, 0, 0, 0, 2'd0));
        idle(16);
        send(8'h6B, "6b_after_to",     o(0, 0, 0, 0, 2'd0));

        // Strobe in the timeout cycle is decoded in the prefix state
        send(8'hE0, "e0_race",         o(0, 0, 0, 0, 2'd1));
        idle(15);
        send(8'h6B, "strobe_wins_to",  o(1, 0, 0, 0, 2'd0));
        send(8'hE0, "e0_race_rel",     o(1, 0, 0, 0, 2'd1));
        send(8'hF0, "f0_race_rel",     o(1, 0, 0, 0, 2'd3));
        send(8'h6B, "race_release",    o(0, 0, 0, 0, 2'd0));

        // Game inactive: outputs gated, breaks still tracked
        send(8'h1C, "norm_left_make",  o(1, 0, 0, 0, 2'd0));
        game_active = 1'b0;
        send(8'h29, "inactive_gate",   o(0, 0, 0, 0, 2'd0));
        send(8'h4D, "inactive_nopause", o(0, 0, 0, 0, 2'd0));
        send(8'hF0, "inactive_f0",     o(0, 0, 0, 0, 2'd2));
        send(8'h1C, "inactive_break",  o(0, 0, 0, 0, 2'd0));
        send(8'hF0, "inactive_f0_p",   o(0, 0, 0, 0, 2'd2));
        send(8'h4D, "inactive_p_brk",  o(0, 0, 0, 0, 2'd0));
        game_active = 1'b1;
        expect_at(cyc + 1, "held_cleared", o(0, 0, 0, 0, 2'd0));
        idle(1);
        send(8'h23, "norm_right_make", o(0, 1, 0, 0, 2'd0));
        send(8'hF0, "right_f0",        o(0, 1, 0, 0, 2'd2));
        send(8'h23, "norm_right_brk",  o(0, 0, 0, 0, 2'd0));

        // Reset mid-sequence discards the prefix
        send(8'hE0, "e0_pre_reset",    o(0, 0, 0, 0, 2'd1));
        rst = 1'b1;
        expect_at(cyc + 1, "reset_mid_seq", o(0, 0, 0, 0, 2'd0));
        @(negedge clk);
        rst = 1'b0;
        send(8'h1C, "1c_after_reset",  o(1, 0, 0, 0, 2'd0));
        send(8'hF0, "f0_after_reset",  o(1, 0, 0, 0, 2'd2));
        send(8'h1C, "1c_break",        o(0, 0, 0, 0, 2'd0));

        for (int i = 0; i < 50 && q_cyc.size() > 0; i++) @(negedge clk);
        if (q_cyc.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, expected 0", q_cyc.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
